// File: rtl/ram_copy_engine.sv
// Block copy engine for a single-port synchronous word RAM: copies len words from src_addr to dst_addr
// under a start/busy/done handshake. Optional running checksum of copied words under `CHECKSUM_EN.
module ram_copy_engine #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [ADDR_WIDTH-1:0] dst_addr,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   words_done,
   output logic [31:0]           checksum,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [31:0]           ram_din,
   input  logic [31:0]           ram_dout
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = 1;
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = 1;

   state_t                state;
   logic [ADDR_WIDTH-1:0] src_ptr;
   logic [ADDR_WIDTH-1:0] dst_ptr;
   logic [ADDR_WIDTH:0]   len_q;
   logic                  last_word;

   assign last_word = (words_done + CNT_ONE) == len_q;

`ifdef CHECKSUM_EN
   logic [31:0] checksum_q;
   assign checksum = checksum_q;
`else
   assign checksum = 32'h0;
`endif

   // Every RAM-facing output is loaded on the edge that enters the state it belongs to, so the
   // port is driven purely from flops and nothing from start/len reaches ram_* combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state and the output flops sit on the async reset so ram_we drops the instant
         // rst rises, without waiting for a clock edge.
         state      <= IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         words_done <= '0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_din    <= '0;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         len_q      <= '0;
`ifdef CHECKSUM_EN
         checksum_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch sees the pre-edge values.
         case (state)
            IDLE: begin
               if (start && len != '0) begin
                  src_ptr    <= src_addr;
                  dst_ptr    <= dst_addr;
                  len_q      <= len;
                  words_done <= '0;
`ifdef CHECKSUM_EN
                  checksum_q <= '0;
`endif
                  ram_addr   <= src_addr;
                  ram_we     <= 1'b0;
                  busy       <= 1'b1;
                  state      <= RD;
               end else if (start) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            RD: state <= CAP;
            CAP: begin
               ram_din  <= ram_dout;
               ram_addr <= dst_ptr;
               ram_we   <= 1'b1;
               state    <= WR;
            end
            WR: begin
               src_ptr    <= src_ptr + PTR_ONE;
               dst_ptr    <= dst_ptr + PTR_ONE;
               words_done <= words_done + CNT_ONE;
`ifdef CHECKSUM_EN
               checksum_q <= checksum_q + ram_din;
`endif
               ram_we     <= 1'b0;
               if (last_word) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  ram_addr <= src_ptr + PTR_ONE;
                  state    <= RD;
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_copy_engine.sv
// Self-checking bench for ram_copy_engine: bench-owned RAM plus an array-level copy model.
// Compile with +define+CHECKSUM_EN to check the checksum build.
module tb_ram_copy_engine;

   localparam int AW = 10;
   localparam int D  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] src_addr;
   logic [AW-1:0] dst_addr;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic [AW:0]   words_done;
   logic [31:0]   checksum;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_din;
   logic [31:0]   ram_dout;

   logic [31:0] mem     [D];
   logic [31:0] ref_mem [D];

   int          n_cmp = 0;
   int          n_bad = 0;
   int          exp_wd;
   logic [31:0] exp_sum;

   ram_copy_engine #(.ADDR_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
      .len(len), .busy(busy), .done(done), .words_done(words_done), .checksum(checksum),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Single-port synchronous RAM with one-cycle registered read.
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < D; i++) if (mem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   function automatic logic [31:0] exp_checksum();
`ifdef CHECKSUM_EN
      return exp_sum;
`else
      return 32'h0;
`endif
   endfunction

   // Reference: sequential ascending word copy with modulo-depth addresses.
   task automatic model_copy(input int s, input int d, input int l);
      if (l == 0) return;
      exp_sum = 32'h0;
      for (int i = 0; i < l; i++) begin
         ref_mem[(d + i) % D] = ref_mem[(s + i) % D];
         exp_sum += ref_mem[(d + i) % D];
      end
      exp_wd = l;
   endtask

   // Called at a negedge with the DUT idle.
   task automatic do_copy(input string tag, input int s, input int d, input int l, input bit spam);
      int  busy_cnt = 0;
      int  done_cnt = 0;
      int  we_cnt   = 0;
      int  overlap  = 0;
      bit  seen     = 1'b0;
      src_addr = s[AW-1:0];
      dst_addr = d[AW-1:0];
      len      = l[AW:0];
      start    = 1'b1;
      @(negedge clk);
      for (int c = 0; c < 3 * D + 20; c++) begin
         if (spam) begin
            start    = 1'($urandom_range(0, 1));
            src_addr = AW'($urandom_range(0, D - 1));
            dst_addr = AW'($urandom_range(0, D - 1));
            len      = (AW + 1)'($urandom_range(0, D));
         end else begin
            start = 1'b0;
         end
         if (busy) busy_cnt++;
         if (done) done_cnt++;
         if (ram_we) we_cnt++;
         if (busy && done) overlap++;
         if (done) begin
            seen  = 1'b1;
            start = 1'b0;
            break;
         end
         @(negedge clk);
      end
      check({tag, "_done_seen"}, 64'(seen), 64'd1);
      @(negedge clk);
      if (done) done_cnt++;
      model_copy(s, d, l);
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(3 * l));
      check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
      check({tag, "_writes"}, 64'(we_cnt), 64'(l));
      check({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
      check({tag, "_idle_busy"}, 64'(busy), 64'd0);
      check({tag, "_words_done"}, 64'(words_done), 64'(exp_wd));
      check({tag, "_checksum"}, 64'(checksum), 64'(exp_checksum()));
      check({tag, "_mem_diffs"}, 64'(mem_diffs()), 64'd0);
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      src_addr = '0;
      dst_addr = '0;
      len      = '0;
      exp_wd   = 0;
      exp_sum  = 32'h0;
      for (int i = 0; i < D; i++) begin
         mem[i]     = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
      for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];

      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_words_done", 64'(words_done), 64'd0);
      check("rst_checksum", 64'(checksum), 64'd0);
      check("rst_ram_we", 64'(ram_we), 64'd0);
      check("rst_ram_addr", 64'(ram_addr), 64'd0);
      check("rst_ram_din", 64'(ram_din), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      do_copy("basic4", 0, 100, 4, 1'b0);
      check("basic4_mem103", 64'(mem[103]), 64'd44);
      do_copy("len0", 7, 9, 0, 1'b0);
      do_copy("src_wrap", 1022, 5, 3, 1'b0);
      check("src_wrap_mem7", 64'(mem[7]), 64'(ref_mem[0]));
      do_copy("dst_wrap", 50, 1022, 4, 1'b0);
      do_copy("overlap_up", 300, 302, 8, 1'b0);

      mem[200] = 32'hFFFF_FFFF; ref_mem[200] = 32'hFFFF_FFFF;
      mem[201] = 32'h2;         ref_mem[201] = 32'h2;
      do_copy("csum", 200, 400, 2, 1'b0);
`ifdef CHECKSUM_EN
      check("csum_wrap_value", 64'(checksum), 64'h1);
`else
      check("csum_tied_zero", 64'(checksum), 64'h0);
`endif

      for (int k = 0; k < 6; k++)
         do_copy($sformatf("rand%0d", k), int'($urandom_range(0, D - 1)),
                 int'($urandom_range(0, D - 1)), int'($urandom_range(1, 40)), 1'b1);

      do_copy("full", int'($urandom_range(0, D - 1)), int'($urandom_range(0, D - 1)), D, 1'b0);

      // Reset during the capture of word 2 of a 4-word copy: only word 1 must land.
      src_addr = AW'(600);
      dst_addr = AW'(700);
      len      = (AW + 1)'(4);
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      ref_mem[700] = ref_mem[600];
      rst = 1'b1;
      #1;
      check("abort_ram_we", 64'(ram_we), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_words_done", 64'(words_done), 64'd0);
      check("abort_ram_addr", 64'(ram_addr), 64'd0);
      check("abort_ram_din", 64'(ram_din), 64'd0);
      check("abort_checksum", 64'(checksum), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("abort_no_done", 64'(done), 64'd0);
      end
      check("abort_mem_diffs", 64'(mem_diffs()), 64'd0);
      exp_wd  = 0;
      exp_sum = 32'h0;

      do_copy("after_abort", 10, 20, 5, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
